resource_arbiter: RTL and testbench

RESOURCE_ARBITER -- requirements
Module: resource_arbiter

---
 rtl/resource_arbiter.sv | 89 ++++++++
 tb/tb_resource_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/resource_arbiter.sv
// rtl/resource_arbiter.sv - round-robin arbiter sharing one fixed-latency resource among NUM_REQ pipelines
module resource_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [WIDTH-1:0]         res_in,
    output logic                     res_in_valid,
    input  logic [WIDTH-1:0]         res_out,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] cand_idx;
    int               cand;

    logic [LATENCY-1:0] tag_valid;
    logic [PTR_W-1:0]   tag_idx [LATENCY];

    // Search ptr+1 .. ptr+NUM_REQ, wrapping at NUM_REQ rather than at 2**PTR_W.
    always_comb begin
        grant        = '0;
        res_in       = '0;
        res_in_valid = 1'b0;
        gnt_idx      = '0;
        cand         = 0;
        cand_idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = cand[PTR_W-1:0];
            if (!res_in_valid && req[cand_idx]) begin
                res_in_valid = 1'b1;
                gnt_idx      = cand_idx;
            end
        end
        if (res_in_valid) begin
            grant[gnt_idx] = 1'b1;
            res_in         = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= PTR_LAST;
            tag_valid <= '0;
        end else begin
            if (res_in_valid) begin
                ptr <= gnt_idx;
            end
            tag_valid[0] <= res_in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
            end
        end
    end

    // Index tags need no reset: they are only looked at through their valid bit.
    always_ff @(posedge clk) begin
        tag_idx[0] <= gnt_idx;
        for (int i = 1; i < LATENCY; i++) begin
            tag_idx[i] <= tag_idx[i-1];
        end
    end

    always_comb begin
        resp_valid = '0;
        if (tag_valid[LATENCY-1]) begin
            resp_valid[tag_idx[LATENCY-1]] = 1'b1;
        end
    end

    assign resp_data = res_out;
    assign busy      = |tag_valid;

endmodule

// File: tb/tb_resource_arbiter.sv
// tb/tb_resource_arbiter.sv - directed self-checking bench for resource_arbiter
module tb_resource_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int L = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   grant;
    logic [W-1:0]   res_in;
    logic           res_in_valid;
    logic [W-1:0]   res_out;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_data;
    logic           busy;

    logic [2:0]     req3;
    logic [23:0]    req_data3;
    logic [2:0]     grant3;
    logic [7:0]     res_in3;
    logic           res_in_valid3;
    logic [7:0]     res_out3;
    logic [2:0]     resp_valid3;
    logic [7:0]     resp_data3;
    logic           busy3;

    logic [W-1:0]   pipe [L];
    int             passed = 0;
    int             total  = 0;

    always #5 clk = ~clk;

    resource_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L)) u_dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .res_in(res_in), .res_in_valid(res_in_valid),
        .res_out(res_out), .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(busy)
    );

    resource_arbiter #(.NUM_REQ(3), .WIDTH(8), .LATENCY(L)) u_dut3 (
        .clk(clk), .reset(reset), .req(req3), .req_data(req_data3),
        .grant(grant3), .res_in(res_in3), .res_in_valid(res_in_valid3),
        .res_out(res_out3), .resp_valid(resp_valid3), .resp_data(resp_data3),
        .busy(busy3)
    );

    // Shared resource model: returns operand + 1 after L cycles.
    always @(posedge clk) begin
        pipe[0] <= res_in + 32'd1;
        for (int i = 1; i < L; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end
    assign res_out   = pipe[L-1];
    assign res_out3  = 8'd0;
    assign req_data3 = 24'h030201;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        req3  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        req3  = '0;
        tick();
        tick();
        settle();
        total++; if (grant !== 4'b0000) $display("FAIL rst_grant: got %b expected %b", grant, 4'b0000); else passed++;
        total++; if (res_in_valid !== 1'b0) $display("FAIL rst_res_in_valid: got %b expected 0", res_in_valid); else passed++;
        total++; if (res_in !== 32'd0) $display("FAIL rst_res_in: got %0d expected 0", res_in); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
        total++; if (resp_valid !== 4'b0000) $display("FAIL rst_resp_valid: got %b expected 0000", resp_valid); else passed++;
        req = 4'b0101;
        #1;
        total++; if (grant !== 4'b0001) $display("FAIL rst_grant_follows_req: got %b expected 0001", grant); else passed++;
        tick();
        req   = '0;
        reset = 1'b0;
    endtask

    task automatic test_first_grant();
        do_reset();
        req_data = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
        req      = 4'b0101;
        settle();
        total++; if (grant !== 4'b0001) $display("FAIL first_grant: got %b expected 0001", grant); else passed++;
        total++; if (res_in !== 32'hA0) $display("FAIL first_res_in: got %h expected a0", res_in); else passed++;
        total++; if (res_in_valid !== 1'b1) $display("FAIL first_res_in_valid: got %b expected 1", res_in_valid); else passed++;
        tick();
        settle();
        total++; if (grant !== 4'b0100) $display("FAIL first_ptr0_grant: got %b expected 0100", grant); else passed++;
        total++; if (res_in !== 32'hC2) $display("FAIL first_ptr0_res_in: got %h expected c2", res_in); else passed++;
        tick();
        req = '0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        logic [N-1:0] exp_r;
        do_reset();
        req_data = {32'd103, 32'd102, 32'd101, 32'd100};
        for (int i = 0; i < 10; i++) begin
            req = (i < 8) ? 4'hF : 4'h0;
            settle();
            exp_g = '0;
            if (i < 8) exp_g[i % 4] = 1'b1;
            exp_r = '0;
            if (i >= 2) exp_r[(i - 2) % 4] = 1'b1;
            total++; if (grant !== exp_g) $display("FAIL rr_grant[%0d]: got %b expected %b", i, grant, exp_g); else passed++;
            total++; if (resp_valid !== exp_r) $display("FAIL rr_resp_valid[%0d]: got %b expected %b", i, resp_valid, exp_r); else passed++;
            if (i >= 2) begin
                total++;
                if (resp_data !== 32'(101 + (i - 2) % 4))
                    $display("FAIL rr_resp_data[%0d]: got %0d expected %0d", i, resp_data, 101 + (i - 2) % 4);
                else passed++;
            end
            tick();
        end
        req = '0;
    endtask

    task automatic test_sole_requester();
        do_reset();
        req_data = '0;
        for (int i = 0; i < 7; i++) begin
            req = (i < 5) ? 4'b0100 : 4'b0000;
            req_data[2*W +: W] = 32'(10 + i);
            settle();
            total++;
            if (grant !== ((i < 5) ? 4'b0100 : 4'b0000))
                $display("FAIL sole_grant[%0d]: got %b expected %b", i, grant, (i < 5) ? 4'b0100 : 4'b0000);
            else passed++;
            if (i >= 2) begin
                total++; if (resp_valid !== 4'b0100) $display("FAIL sole_resp_valid[%0d]: got %b expected 0100", i, resp_valid); else passed++;
                total++; if (resp_data !== 32'(9 + i)) $display("FAIL sole_resp_data[%0d]: got %0d expected %0d", i, resp_data, 9 + i); else passed++;
            end else begin
                total++; if (resp_valid !== 4'b0000) $display("FAIL sole_resp_early[%0d]: got %b expected 0000", i, resp_valid); else passed++;
            end
            tick();
        end
        req = '0;
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        req = 4'b0001;
        settle();
        total++; if (grant !== 4'b0001) $display("FAIL mid_grant: got %b expected 0001", grant); else passed++;
        tick();
        reset = 1'b1;
        settle();
        total++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", busy); else passed++;
        tick();
        reset = 1'b0;
        req   = '0;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++; if (resp_valid !== 4'b0000) $display("FAIL mid_resp_valid[%0d]: got %b expected 0000", i, resp_valid); else passed++;
            total++; if (busy !== 1'b0) $display("FAIL mid_busy[%0d]: got %b expected 0", i, busy); else passed++;
            tick();
        end
    endtask

    task automatic test_idle();
        do_reset();
        req_data = {32'd4, 32'd3, 32'd2, 32'd1};
        req = 4'b0010;
        for (int i = 0; i < 3; i++) tick();
        req = '0;
        for (int j = 0; j < 10; j++) begin
            settle();
            total++; if (grant !== 4'b0000) $display("FAIL idle_grant[%0d]: got %b expected 0000", j, grant); else passed++;
            total++; if (res_in_valid !== 1'b0) $display("FAIL idle_res_in_valid[%0d]: got %b expected 0", j, res_in_valid); else passed++;
            total++; if (res_in !== 32'd0) $display("FAIL idle_res_in[%0d]: got %0d expected 0", j, res_in); else passed++;
            total++; if (busy !== (j < 2)) $display("FAIL idle_busy[%0d]: got %b expected %b", j, busy, (j < 2)); else passed++;
            tick();
        end
        req = 4'hF;
        settle();
        total++; if (grant !== 4'b0100) $display("FAIL idle_ptr_held: got %b expected 0100", grant); else passed++;
        tick();
        req = '0;
    endtask

    task automatic test_wrap_three();
        logic [2:0] exp3;
        do_reset();
        req3 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            settle();
            exp3 = '0;
            exp3[i % 3] = 1'b1;
            total++; if (grant3 !== exp3) $display("FAIL wrap3_grant[%0d]: got %b expected %b", i, grant3, exp3); else passed++;
            tick();
        end
        req3 = 3'b100;
        settle();
        total++; if (grant3 !== 3'b100) $display("FAIL wrap3_to2: got %b expected 100", grant3); else passed++;
        total++; if (res_in3 !== 8'h03) $display("FAIL wrap3_res_in: got %h expected 03", res_in3); else passed++;
        tick();
        req3 = 3'b011;
        settle();
        total++; if (grant3 !== 3'b001) $display("FAIL wrap3_from2: got %b expected 001", grant3); else passed++;
        tick();
        req3 = '0;
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req3     = '0;
        req_data = '0;
        test_reset();
        test_first_grant();
        test_round_robin();
        test_sole_requester();
        test_reset_mid_flight();
        test_idle();
        test_wrap_three();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
